fp_mult_pipe: RTL and testbench

//   Pipelined sign/exponent/mantissa floating-point multiplier, the parametrised successor to the

---
 rtl/fp_mult_pipe_if.sv | 27 ++
 rtl/fp_mult_pipe.sv | 109 ++++++++++
 tb/tb_fp_mult_pipe.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/fp_mult_pipe_if.sv
// fp_mult_pipe_if: operand/product stream bundle for fp_mult_pipe.
//   master side (producer/consumer) drives i_valid, i_flotante_1/2, i_ready;
//   slave side (multiplier) drives o_ready, o_flotante, o_valid, o_ovf, o_unf.
//   Word layout {sign, exponent[NB_EXP], mantissa[NB_MAN]}.
interface fp_mult_pipe_if #(
    parameter int NB_EXP = 4,
    parameter int NB_MAN = 8
);
    localparam int NB_W = 1 + NB_EXP + NB_MAN;
    logic            i_valid;
    logic            o_ready;
    logic [NB_W-1:0] i_flotante_1;
    logic [NB_W-1:0] i_flotante_2;
    logic [NB_W-1:0] o_flotante;
    logic            o_valid;
    logic            i_ready;
    logic            o_ovf;
    logic            o_unf;
    modport master (
        output i_valid, i_flotante_1, i_flotante_2, i_ready,
        input  o_ready, o_flotante, o_valid, o_ovf, o_unf
    );
    modport slave (
        input  i_valid, i_flotante_1, i_flotante_2, i_ready,
        output o_ready, o_flotante, o_valid, o_ovf, o_unf
    );
endinterface

// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: 3-stage floating-point multiplier with valid/ready stall and ovf/unf flags.
//   clock    : rising-edge system clock
//   i_rst_n  : asynchronous active-low reset, empties the pipeline
//   bus      : fp_mult_pipe_if.slave (operands in, product + flags out, handshakes)
//   Optional FP_MULT_ROUND_EN: round-to-nearest-even; otherwise truncate toward zero.
module fp_mult_pipe #(
    parameter int NB_EXP = 4,
    parameter int NB_MAN = 8
) (
    input logic           clock,
    input logic           i_rst_n,
    fp_mult_pipe_if.slave bus
);
    localparam int NB_W = 1 + NB_EXP + NB_MAN;
    localparam int NB_P = 2 * NB_MAN + 2;
    localparam int NB_E = NB_EXP + 2;
    localparam logic [NB_E-1:0] BIAS = {3'b000, {(NB_EXP-1){1'b1}}};

    logic              en;
    logic              v1_q, v1_d, z1_q, z1_d;
    logic [NB_W-1:0]   a1_q, a1_d, b1_q, b1_d;
    logic              v2_q, v2_d, z2_q, z2_d, s2_q, s2_d;
    logic [NB_P-1:0]   p2_q, p2_d;
    logic [NB_E-1:0]   e2_q, e2_d;
    logic              v3_q, v3_d, ovf_q, ovf_d, unf_q, unf_d;
    logic [NB_W-1:0]   res_q, res_d;
    logic [NB_P-2:0]   pn;
    logic [NB_MAN-1:0] frac;
    logic              carry, ovf, unf;
    logic [NB_E-1:0]   e3;
`ifndef FP_MULT_ROUND_EN
    logic [NB_MAN:0]   tail_unused;
`endif

    // Whole pipeline freezes while the output word waits on the consumer.
    assign en = ~(v3_q & ~bus.i_ready);

    always_comb begin
        v1_d = bus.i_valid;
        a1_d = bus.i_flotante_1;
        b1_d = bus.i_flotante_2;
        z1_d = ~|bus.i_flotante_1[NB_MAN +: NB_EXP] | ~|bus.i_flotante_2[NB_MAN +: NB_EXP];
        v2_d = v1_q;
        z2_d = z1_q;
        s2_d = a1_q[NB_W-1] ^ b1_q[NB_W-1];
        p2_d = {{(NB_MAN+1){1'b0}}, 1'b1, a1_q[NB_MAN-1:0]} *
               {{(NB_MAN+1){1'b0}}, 1'b1, b1_q[NB_MAN-1:0]};
        // Modular arithmetic: the NB_E-bit result is the two's-complement exponent.
        e2_d = {2'b00, a1_q[NB_MAN +: NB_EXP]} + {2'b00, b1_q[NB_MAN +: NB_EXP]} - BIAS;
        // Product in [1,4): align so the leading one sits just above pn, dropping it.
        pn = p2_q[NB_P-1] ? p2_q[NB_P-2:0] : {p2_q[NB_P-3:0], 1'b0};
`ifdef FP_MULT_ROUND_EN
        // Guard = pn[NB_MAN]; round|sticky = OR of the rest; ties go to even lsb.
        {carry, frac} = {1'b0, pn[NB_P-2 -: NB_MAN]} +
                        {{NB_MAN{1'b0}}, pn[NB_MAN] & ((|pn[NB_MAN-1:0]) | pn[NB_MAN+1])};
`else
        {carry, frac} = {1'b0, pn[NB_P-2 -: NB_MAN]};
        tail_unused = pn[NB_MAN:0];
`endif
        // A rounding carry leaves frac all zeros, i.e. 10.0 renormalised to 1.0.
        e3 = e2_q + {{(NB_E-1){1'b0}}, p2_q[NB_P-1]} + {{(NB_E-1){1'b0}}, carry};
        ovf = ~e3[NB_E-1] & e3[NB_E-2];
        unf = e3[NB_E-1] | ~|e3;
        v3_d = v2_q;
        ovf_d = ~z2_q & ovf;
        unf_d = ~z2_q & unf;
        res_d = (z2_q | unf) ? '0 :
                ovf          ? {s2_q, {(NB_W-1){1'b1}}} :
                               {s2_q, e3[NB_EXP-1:0], frac};
    end

    always_ff @(posedge clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v1_q  <= 1'b0;
            z1_q  <= 1'b0;
            a1_q  <= '0;
            b1_q  <= '0;
            v2_q  <= 1'b0;
            z2_q  <= 1'b0;
            s2_q  <= 1'b0;
            p2_q  <= '0;
            e2_q  <= '0;
            v3_q  <= 1'b0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            res_q <= '0;
        end else if (en) begin
            v1_q  <= v1_d;
            z1_q  <= z1_d;
            a1_q  <= a1_d;
            b1_q  <= b1_d;
            v2_q  <= v2_d;
            z2_q  <= z2_d;
            s2_q  <= s2_d;
            p2_q  <= p2_d;
            e2_q  <= e2_d;
            v3_q  <= v3_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            res_q <= res_d;
        end
    end

    assign bus.o_ready    = en;
    assign bus.o_valid    = v3_q;
    assign bus.o_flotante = res_q;
    assign bus.o_ovf      = ovf_q;
    assign bus.o_unf      = unf_q;
endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb_fp_mult_pipe: directed-vector bench for fp_mult_pipe (default 1/4/8 format).
module tb_fp_mult_pipe;
    logic clock = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [12:0] got[$];

    localparam logic [12:0] A1 = 13'h15C6, B1 = 13'h0C1D, R1 = 13'h1AF9;
    localparam logic [12:0] A2 = 13'h03CD, B2 = 13'h1B2B, R2 = 13'h180D;
    localparam logic [12:0] A3 = 13'h0C1D, B3 = 13'h03CD;
`ifdef FP_MULT_ROUND_EN
    localparam logic [12:0] R3 = 13'h0901;
`else
    localparam logic [12:0] R3 = 13'h0900;
`endif

    always #5 clock = ~clock;

    fp_mult_pipe_if #(.NB_EXP(4), .NB_MAN(8)) bus ();

    fp_mult_pipe #(.NB_EXP(4), .NB_MAN(8)) dut (
        .clock  (clock),
        .i_rst_n(rst_n),
        .bus    (bus.slave)
    );

    always @(negedge clock) begin
        #1;
        if (bus.o_valid && bus.i_ready) got.push_back(bus.o_flotante);
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    task automatic run_one(input string tag, input logic [12:0] a, input logic [12:0] b,
                           input logic [12:0] r, input logic ov, input logic un);
        @(negedge clock);
        bus.i_valid = 1'b1;
        bus.i_flotante_1 = a;
        bus.i_flotante_2 = b;
        @(negedge clock);
        bus.i_valid = 1'b0;
        @(negedge clock);
        chk({tag, "_early"}, 16'(bus.o_valid), 16'd0);
        @(negedge clock);
        chk({tag, "_valid"}, 16'(bus.o_valid), 16'd1);
        chk({tag, "_res"}, 16'(bus.o_flotante), 16'(r));
        chk({tag, "_ovf"}, 16'(bus.o_ovf), 16'(ov));
        chk({tag, "_unf"}, 16'(bus.o_unf), 16'(un));
    endtask

    initial begin
        logic [12:0] exp_q [3];
        exp_q[0] = R1;
        exp_q[1] = R2;
        exp_q[2] = R3;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        bus.i_flotante_1 = '0;
        bus.i_flotante_2 = '0;
        #1;
        chk("rst_valid", 16'(bus.o_valid), 16'd0);
        chk("rst_res", 16'(bus.o_flotante), 16'd0);
        chk("rst_ovf", 16'(bus.o_ovf), 16'd0);
        chk("rst_unf", 16'(bus.o_unf), 16'd0);
        chk("rst_ready", 16'(bus.o_ready), 16'd1);
        repeat (2) @(negedge clock);
        rst_n = 1'b1;

        run_one("t1", A1, B1, R1, 1'b0, 1'b0);
        run_one("t2", A2, B2, R2, 1'b0, 1'b0);
        run_one("t3", A3, B3, R3, 1'b0, 1'b0);
        run_one("ovf", 13'h0FFF, 13'h0FFF, 13'h0FFF, 1'b1, 1'b0);
        run_one("unf", 13'h0100, 13'h0100, 13'h0000, 1'b0, 1'b1);
        run_one("zero", 13'h0000, 13'h0C1D, 13'h0000, 1'b0, 1'b0);

        // Back-to-back stream with a 4-cycle downstream stall.
        @(negedge clock);
        got.delete();
        bus.i_valid = 1'b1;
        bus.i_flotante_1 = A1;
        bus.i_flotante_2 = B1;
        @(negedge clock);
        bus.i_flotante_1 = A2;
        bus.i_flotante_2 = B2;
        @(negedge clock);
        bus.i_flotante_1 = A3;
        bus.i_flotante_2 = B3;
        @(negedge clock);
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("stall_ready", 16'(bus.o_ready), 16'd0);
            chk("stall_valid", 16'(bus.o_valid), 16'd1);
            chk("stall_hold", 16'(bus.o_flotante), 16'(R1));
            @(negedge clock);
        end
        bus.i_ready = 1'b1;
        for (int i = 0; i < 20 && got.size() < 3; i++) @(negedge clock);
        repeat (4) @(negedge clock);
        chk("stream_count", 16'(got.size()), 16'd3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("stream_%0d", i), (i < got.size()) ? 16'(got[i]) : 16'hxxxx, 16'(exp_q[i]));

        // Reset with two results in flight, the oldest parked at the output.
        got.delete();
        bus.i_ready = 1'b0;
        @(negedge clock);
        bus.i_valid = 1'b1;
        bus.i_flotante_1 = A1;
        bus.i_flotante_2 = B1;
        @(negedge clock);
        bus.i_flotante_1 = A2;
        bus.i_flotante_2 = B2;
        @(negedge clock);
        bus.i_valid = 1'b0;
        @(negedge clock);
        #1;
        chk("inflight_valid", 16'(bus.o_valid), 16'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 16'(bus.o_valid), 16'd0);
        chk("midrst_res", 16'(bus.o_flotante), 16'd0);
        @(negedge clock);
        rst_n = 1'b1;
        bus.i_ready = 1'b1;
        repeat (6) @(negedge clock);
        chk("post_rst_empty", 16'(got.size()), 16'd0);
        run_one("post_rst", A1, B1, R1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
